// File: rtl/add.sv
// Registered WIDTH-bit adder for the datapath address/PC path.
// The carries come from 4-bit carry-lookahead groups. A lookahead stage
// over the group generate/propagate pairs links the groups. The sum and the
// carry, overflow and zero flags are registered behind a valid strobe.
module add #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] Add_a,
   input  logic [WIDTH-1:0] Add_b,
   output logic [WIDTH-1:0] Add_c,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid
);

   localparam int NG = WIDTH / 4;

   // Carry into each bit of a 4-bit group, given the group's carry-in.
   function automatic logic [3:0] cla4_carry(input logic [3:0] g,
                                             input logic [3:0] p,
                                             input logic       cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
             (p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

   // Group generate (bit 1) and group propagate (bit 0) of a 4-bit group.
   function automatic logic [1:0] cla4_gp(input logic [3:0] g,
                                          input logic [3:0] p);
      logic grp_g;
      logic grp_p;
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      return {grp_g, grp_p};
   endfunction

   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] p_s;
   logic [NG-1:0]    grp_g_s;
   logic [NG-1:0]    grp_p_s;
   logic [NG:0]      grp_c_s;
   logic [WIDTH-1:0] c_s;

   logic [WIDTH-1:0] sum_d;
   logic             carry_d;
   logic             overflow_d;
   logic             zero_d;

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             overflow_q;
   logic             zero_q;
   logic             valid_q;

   // Per-bit generate and propagate terms.
   always_comb begin
      g_s = Add_a & Add_b;
      p_s = Add_a ^ Add_b;
   end

   // Collapse each 4-bit slice into a group generate/propagate pair.
   always_comb begin
      grp_g_s = {NG{1'b0}};
      grp_p_s = {NG{1'b0}};
      for (int k = 0; k < NG; k++) begin
         {grp_g_s[k], grp_p_s[k]} = cla4_gp(g_s[4*k +: 4], p_s[4*k +: 4]);
      end
   end

   // Group-level lookahead. Each group carry is the OR of every lower group
   // generate propagated through all groups above it. The adder carry-in is 0.
   always_comb begin
      logic term;
      term    = 1'b0;
      grp_c_s = {(NG+1){1'b0}};
      for (int k = 0; k < NG; k++) begin
         for (int j = 0; j <= k; j++) begin
            term = grp_g_s[j];
            for (int m = j + 1; m <= k; m++) begin
               term = term & grp_p_s[m];
            end
            grp_c_s[k+1] = grp_c_s[k+1] | term;
         end
      end
   end

   // Expand each group carry-in into the carries for its four bits.
   always_comb begin
      c_s = {WIDTH{1'b0}};
      for (int k = 0; k < NG; k++) begin
         c_s[4*k +: 4] = cla4_carry(g_s[4*k +: 4], p_s[4*k +: 4], grp_c_s[k]);
      end
   end

   // Sum bits and flags presented to the output registers.
   always_comb begin
      sum_d      = p_s ^ c_s;
      carry_d    = grp_c_s[NG];
      overflow_d = (Add_a[WIDTH-1] ~^ Add_b[WIDTH-1]) &
                   (sum_d[WIDTH-1] ^ Add_a[WIDTH-1]);
      zero_d     = ~|sum_d;
   end

   // Output registers. A valid strobe loads the result. Without the strobe the
   // result holds and only the valid flag drops. Reset wins over the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q      <= {WIDTH{1'b0}};
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b1;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
         end else begin
            sum_q      <= sum_q;
            carry_q    <= carry_q;
            overflow_q <= overflow_q;
            zero_q     <= zero_q;
         end
      end
   end

   assign Add_c     = sum_q;
   assign carry_out = carry_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_add.sv
// Bench for the registered adder. It drives a 32-bit and an 8-bit instance
// with the same stimulus. An arithmetic reference model predicts the outputs
// of each instance. It runs directed corner cases and then randomized pairs
// with occasional idle cycles and mid-stream resets.
module tb_add;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a_s;
   logic [31:0] b_s;

   logic [31:0] c32;
   logic        co32, ov32, z32, v32;
   logic [7:0]  c8;
   logic        co8, ov8, z8, v8;

   int checks   = 0;
   int failures = 0;

   // Reference state, index 0 = WIDTH 32, index 1 = WIDTH 8.
   longint m_c  [2];
   logic   m_co [2];
   logic   m_ov [2];
   logic   m_z  [2];
   logic   m_v  [2];

   add #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .Add_a(a_s), .Add_b(b_s),
      .Add_c(c32), .carry_out(co32), .overflow(ov32), .zero(z32),
      .out_valid(v32)
   );

   add #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .Add_a(a_s[7:0]), .Add_b(b_s[7:0]),
      .Add_c(c8), .carry_out(co8), .overflow(ov8), .zero(z8),
      .out_valid(v8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands truncated to width.
   task automatic model_step(input logic r, input logic v,
                             input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 2; i++) begin
         longint w, full, half, ua, ub, sa, sb, sum, ss;
         w    = (i == 0) ? 64'sd32 : 64'sd8;
         full = 64'sd1 <<< w;
         half = 64'sd1 <<< (w - 64'sd1);
         ua   = longint'(a) % full;
         ub   = longint'(b) % full;
         sa   = (ua >= half) ? ua - full : ua;
         sb   = (ub >= half) ? ub - full : ub;
         sum  = ua + ub;
         ss   = sa + sb;
         if (r) begin
            m_c[i] = 0; m_co[i] = 1'b0; m_ov[i] = 1'b0;
            m_z[i] = 1'b1; m_v[i] = 1'b0;
         end else begin
            m_v[i] = v;
            if (v) begin
               m_c[i]  = sum % full;
               m_co[i] = (sum >= full);
               m_ov[i] = (ss >= half) || (ss < -half);
               m_z[i]  = (m_c[i] == 0);
            end
         end
      end
   endtask

   // One clock: apply inputs, update the model at the edge, compare after it.
   task automatic cycle(input string tag, input logic r, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
      rst = r; in_valid = v; a_s = a; b_s = b;
      @(posedge clk);
      model_step(r, v, a, b);
      #1;
      check_eq({tag, "_c32"},  c32,           32'(m_c[0]));
      check_eq({tag, "_co32"}, {31'd0, co32}, {31'd0, m_co[0]});
      check_eq({tag, "_ov32"}, {31'd0, ov32}, {31'd0, m_ov[0]});
      check_eq({tag, "_z32"},  {31'd0, z32},  {31'd0, m_z[0]});
      check_eq({tag, "_v32"},  {31'd0, v32},  {31'd0, m_v[0]});
      check_eq({tag, "_c8"},   {24'd0, c8},   32'(m_c[1]));
      check_eq({tag, "_co8"},  {31'd0, co8},  {31'd0, m_co[1]});
      check_eq({tag, "_ov8"},  {31'd0, ov8},  {31'd0, m_ov[1]});
      check_eq({tag, "_z8"},   {31'd0, z8},   {31'd0, m_z[1]});
      check_eq({tag, "_v8"},   {31'd0, v8},   {31'd0, m_v[1]});
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0:       r = 32'h0000_0000;
         1:       r = 32'hFFFF_FFFF;
         2:       r = 32'h7FFF_FFFF;
         3:       r = 32'h8000_0000;
         4:       r = 32'h0000_007F;
         default: r = $urandom;
      endcase
      return r;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; a_s = 32'd0; b_s = 32'd0;

      cycle("rst0", 1'b1, 1'b0, 32'd0, 32'd0);
      cycle("rst1", 1'b1, 1'b0, 32'd0, 32'd0);
      cycle("idle", 1'b0, 1'b0, 32'd0, 32'd0);
      check_eq("reset_c", c32, 32'h0);
      check_eq("reset_z", {31'd0, z32}, 32'd1);
      check_eq("reset_v", {31'd0, v32}, 32'd0);

      cycle("s11", 1'b0, 1'b1, 32'h0000_0011, 32'h0000_0001);
      check_eq("dir_12", c32, 32'h0000_0012);
      check_eq("dir_12_v", {31'd0, v32}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            cycle("tog0", 1'b0, 1'b1, 32'd0, 32'd0);
            check_eq("tog0_z", {31'd0, z32}, 32'd1);
         end else begin
            cycle("tog1", 1'b0, 1'b1, 32'd1, 32'd1);
            check_eq("tog1_c", c32, 32'h0000_0002);
         end
      end

      cycle("wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      check_eq("wrap_co", {31'd0, co32}, 32'd1);
      check_eq("wrap_ov", {31'd0, ov32}, 32'd0);
      cycle("povf", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
      check_eq("povf_c", c32, 32'h8000_0000);
      check_eq("povf_ov", {31'd0, ov32}, 32'd1);
      check_eq("povf_co", {31'd0, co32}, 32'd0);
      cycle("novf", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
      check_eq("novf_co", {31'd0, co32}, 32'd1);
      check_eq("novf_ov", {31'd0, ov32}, 32'd1);
      check_eq("novf_z", {31'd0, z32}, 32'd1);
      cycle("hold", 1'b0, 1'b0, 32'h1234_0000, 32'h0000_5678);
      check_eq("hold_c", c32, 32'h0);
      check_eq("hold_v", {31'd0, v32}, 32'd0);

      cycle("strm0", 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200);
      cycle("mrst",  1'b1, 1'b1, 32'h0000_0300, 32'h0000_0400);
      check_eq("mrst_c", c32, 32'h0);
      check_eq("mrst_v", {31'd0, v32}, 32'd0);
      cycle("post", 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111);
      check_eq("post_c", c32, 32'h2345_6789);

      for (int i = 0; i < 1000; i++) begin
         logic r, v;
         r = ($urandom_range(0, 63) == 0);
         v = ($urandom_range(0, 7) != 0);
         cycle("rnd", r, v, pick_operand(), pick_operand());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add.md
Name: add

Overview:
- Registered WIDTH-bit two's-complement/unsigned adder used as the address/PC adder in the single-cycle processor datapath.
- Computes Add_c = Add_a + Add_b, modulo 2^WIDTH, plus carry, signed-overflow and zero flags.
- Result and flags are registered: one cycle of latency, qualified by a valid strobe.
- Carry logic is built from 4-bit carry-lookahead groups chained by a group-level lookahead, not a behavioural "+".

Parameters:
- WIDTH, 32, operand/result width in bits; must be a positive multiple of 4.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, synchronous reset, active-high.
- in_valid, input, 1, operands on Add_a/Add_b are to be summed this cycle.
- Add_a, input, WIDTH, first operand.
- Add_b, input, WIDTH, second operand.
- Add_c, output, WIDTH, registered sum, low WIDTH bits of Add_a + Add_b.
- carry_out, output, 1, registered carry out of bit WIDTH-1 (unsigned overflow).
- overflow, output, 1, registered signed overflow: operands have the same sign and the sum sign differs.
- zero, output, 1, registered flag, 1 when Add_c is all zeros.
- out_valid, output, 1, registered copy of in_valid; Add_c and the flags are meaningful when this is 1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: on a clk edge with rst=1, Add_c=0, carry_out=0, overflow=0, zero=1 and out_valid=0. Reset overrides in_valid in the same cycle.
- Combinational core:
  - Per-bit generate g=a&b and propagate p=a^b.
  - Each 4-bit group produces internal carries, a group generate G and a group propagate P.
  - Group carries come from a lookahead chain over the G/P pairs, with carry-in 0.
  - Sum bit = p ^ carry-in to that bit.
- Latency: with in_valid=1 at edge N, the sum and flags of the operands sampled at edge N appear after edge N, and out_valid=1 after edge N.
- in_valid=0 at an edge: out_valid goes to 0. Add_c and the flags hold their previous values and do not update.
- Wrap-around: the result is modulo 2^WIDTH. For example, 0xFFFFFFFF+1 gives Add_c=0, carry_out=1, zero=1, overflow=0.
- Signed overflow follows the rule above, e.g. 0x7FFFFFFF+1 gives overflow=1, carry_out=0.
- Back-to-back in_valid=1 every cycle is supported at full throughput with no stalls; there is no back-pressure.
- rst asserted mid-stream discards any pending result. Output returns to the reset values at that edge.
- Operands may change every cycle. Only the values present at the sampling edge matter.
- No X propagation from the registers after reset. Outputs are defined from the first reset edge onward.

Test Plan:
- rst=1 for 2 cycles, then rst=0 with in_valid=0 -> Add_c=0, zero=1, carry_out=0, overflow=0, out_valid=0.
- in_valid=1, Add_a=0x00000011, Add_b=0x00000001 -> next cycle Add_c=0x00000012, out_valid=1, all flags 0.
- Operands toggle each cycle between 0/0 and 1/1 with in_valid=1:
  - 0/0 -> Add_c=0, zero=1.
  - 1/1 -> Add_c=0x00000002, zero=0.
  - Each result appears exactly one cycle after its operands.
- Add_a=0xFFFFFFFF, Add_b=0x00000001 -> Add_c=0, carry_out=1, zero=1, overflow=0. Then Add_a=0x7FFFFFFF, Add_b=0x00000001 -> Add_c=0x80000000, overflow=1, carry_out=0.
- Add_a=0x80000000, Add_b=0x80000000 -> Add_c=0, carry_out=1, overflow=1, zero=1. Then drop in_valid -> out_valid=0, Add_c holds 0.
- Stream in_valid=1 and assert rst for one cycle mid-stream:
  - After the reset edge, outputs equal the reset values.
  - The next valid operand pair, e.g. 0x12345678+0x11111111, gives Add_c=0x23456789 one cycle later.
  - Also run 1000 random pairs checked against a behavioural reference, with WIDTH=32 and WIDTH=8.
